// File: rtl/mem_arbiter_pkg.sv
// Shared widths, encodings and helpers for the cache-to-memory arbiter.
// Line and address widths follow the iCache line and virtual address sizes.
package mem_arbiter_pkg;

  localparam int ICACHE_LINE_WIDTH  = 128;
  localparam int VIRT_ADDR_WIDTH    = 32;
  localparam int MEM_TIMEOUT_CYCLES = 64;

  // Byte-offset bits inside one memory line.
  localparam int LINE_OFS_W = 4;

  typedef enum logic [1:0] {
    MEMARB_IDLE = 2'd0,
    MEMARB_BUSY = 2'd1,
    MEMARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_own_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: clear on grant, count while waiting, flag expiry.
// TIMEOUT_CYCLES of 0 removes the counter and never expires.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk_i, rst_ni, clr_i, en_i};
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST =
        CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Expires on the edge that would complete the last waited cycle.
      assign expired_o = en_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// iCache / dCache arbiter for the single line-wide memory port.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed dCache priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_W         = ICACHE_LINE_WIDTH,
  parameter int ADDR_W         = VIRT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_data,
  output logic              ic_data_ready,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_data,
  output logic              dc_data_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);

  arb_state_e state_q, state_d;
  arb_own_e   own_q, own_d;

  logic [ADDR_W-1:LINE_OFS_W] addr_q, addr_d;
  logic                       we_q, we_d;
  logic [LINE_W-1:0]          wdata_q, wdata_d;
  logic [LINE_W-1:0]          ic_line_q, ic_line_d;
  logic [LINE_W-1:0]          dc_line_q, dc_line_d;
  logic                       err_q, err_d;

  logic grant;
  logic dc_win;
  logic wd_clr;
  logic wd_en;
  logic wd_exp;

  // Line offsets never reach memory.
  logic unused_ofs;
  assign unused_ofs =
    ^{ic_addr[LINE_OFS_W-1:0], dc_addr[LINE_OFS_W-1:0]};

`ifdef MEM_ARB_RR_EN
  // Pointer holds the last granted owner; the other side wins a tie.
  arb_own_e rr_q, rr_d;

  assign dc_win = dc_req && (!ic_req || (rr_q == OWN_IC));

  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = own_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= OWN_IC;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign dc_win = dc_req;
`endif

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_exp)
  );

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ic_line_d = ic_line_q;
    dc_line_d = dc_line_q;
    err_d     = 1'b0;
    grant     = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    unique case (state_q)
      MEMARB_IDLE: begin
        if (ic_req || dc_req) begin
          grant   = 1'b1;
          wd_clr  = 1'b1;
          state_d = MEMARB_BUSY;
          if (dc_win) begin
            own_d   = OWN_DC;
            addr_d  = dc_addr[ADDR_W-1:LINE_OFS_W];
            we_d    = dc_we;
            wdata_d = dc_we ? dc_wdata : '0;
          end else begin
            own_d   = OWN_IC;
            addr_d  = ic_addr[ADDR_W-1:LINE_OFS_W];
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      MEMARB_BUSY: begin
        wd_en = !mem_ack;
        if (mem_ack) begin
          state_d = MEMARB_RESP;
          if (!we_q) begin
            if (own_q == OWN_DC) begin
              dc_line_d = mem_rdata;
            end else begin
              ic_line_d = mem_rdata;
            end
          end
        end else if (wd_exp) begin
          // Abort: the still-held request re-arbitrates from IDLE.
          state_d = MEMARB_IDLE;
          err_d   = 1'b1;
        end
      end
      MEMARB_RESP: begin
        state_d = MEMARB_IDLE;
      end
      default: begin
        state_d = MEMARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MEMARB_IDLE;
      own_q     <= OWN_IC;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ic_line_q <= '0;
      dc_line_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
      err_q     <= err_d;
    end
  end

  logic busy;
  logic resp;
  logic wr_own;

  assign busy   = (state_q == MEMARB_BUSY);
  assign resp   = (state_q == MEMARB_RESP);
  assign wr_own = (own_q == OWN_DC) && we_q;

  assign mem_req   = busy;
  assign mem_we    = busy && wr_own;
  assign mem_addr  = busy ?
    {addr_q, {LINE_OFS_W{1'b0}}} : '0;
  assign mem_wdata = (busy && wr_own) ? wdata_q : '0;
  assign mem_err   = err_q;

  assign ic_data       = ic_line_q;
  assign dc_data       = dc_line_q;
  assign ic_data_ready = resp && (own_q == OWN_IC);
  assign dc_data_ready = resp && (own_q == OWN_DC);

endmodule
